// File: rtl/fprenorm_pkg.sv
// Shared FPU configuration for the left-normalizer: format widths, FSM state type
// and the result payload carried to the divsqrt/FMA front ends.
package fprenorm_pkg;

    localparam int unsigned NF    = 52;
    localparam int unsigned NE    = 11;
    localparam int unsigned STEP  = 4;
    localparam int unsigned MW    = NF + 1;
    localparam int unsigned EW    = NE + 2;
    localparam int unsigned LOGNF = $clog2(NF + 1);
    localparam int unsigned LZW   = $clog2(STEP + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

    typedef struct packed {
        logic [MW-1:0]    m;
        logic [EW-1:0]    e;
        logic             zero;
        logic [LOGNF-1:0] shift;
    } resultT;

    // Subnormals share the exponent of the smallest normal before shifting.
    function automatic logic [EW-1:0] unpackExp(input logic [NE-1:0] e);
        return (e == '0) ? EW'(1) : EW'(e);
    endfunction

endpackage

// File: rtl/fprenorm_if.sv
// Operand/result handshake bundle between unpack (master) and the normalizer (slave).
interface fprenorm_if;
    import fprenorm_pkg::*;

    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [MW-1:0]    InM;
    logic [NE-1:0]    InE;
    logic             OutValid;
    logic             OutReady;
    logic [MW-1:0]    OutM;
    logic [EW-1:0]    OutE;
    logic             OutZero;
    logic [LOGNF-1:0] OutShift;

    modport master (
        output Flush, InValid, InM, InE, OutReady,
        input  InReady, OutValid, OutM, OutE, OutZero, OutShift
    );

    modport slave (
        input  Flush, InValid, InM, InE, OutReady,
        output InReady, OutValid, OutM, OutE, OutZero, OutShift
    );

endinterface

// File: rtl/fprenorm_lzc.sv
// Leading-zero counter over a W-bit window; all-zero input reports W.
module fprenorm_lzc #(
    parameter  int unsigned W  = 4,
    localparam int unsigned ZW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a,
    output logic [ZW-1:0] z
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        z = ZW'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (a[i]) begin
                z = ZW'(int'(W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fprenorm.sv
// Iterative left-normalizer: shifts subnormal significands up to STEP bits per cycle
// until the leading one reaches the MSB, tracking exponent and total shift.
module fprenorm
    import fprenorm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    fprenorm_if.slave  io
);

    stateT          state;
    resultT         res;
    logic           outValid;
    logic           accept;
    logic [LZW-1:0] lz;

    fprenorm_lzc #(.W(STEP)) uLzc (
        .a (res.m[NF -: STEP]),
        .z (lz)
    );

    assign io.InReady  = (state == IDLE) & ~reset;
    assign accept      = io.InValid & io.InReady & ~io.Flush;

    assign io.OutValid = outValid;
    assign io.OutM     = res.m;
    assign io.OutE     = res.e;
    assign io.OutZero  = res.zero;
    assign io.OutShift = res.shift;

    // Flush outranks every transition; the result register keeps its stale value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            outValid <= 1'b0;
            res      <= '0;
        end else if (io.Flush) begin
            state    <= IDLE;
            outValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        res.shift <= '0;
                        if (io.InM == '0) begin
                            res.m    <= '0;
                            res.e    <= '0;
                            res.zero <= 1'b1;
                            state    <= DONE;
                            outValid <= 1'b1;
                        end else begin
                            res.m    <= io.InM;
                            res.e    <= unpackExp(io.InE);
                            res.zero <= 1'b0;
                            if (io.InM[NF]) begin
                                state    <= DONE;
                                outValid <= 1'b1;
                            end else begin
                                state <= SHIFT;
                            end
                        end
                    end
                end
                SHIFT: begin
                    res.m     <= res.m << lz;
                    res.e     <= res.e - EW'(lz);
                    res.shift <= res.shift + LOGNF'(lz);
                    // A partial window means the leading one lands at the MSB this cycle.
                    if (lz != LZW'(STEP)) begin
                        state    <= DONE;
                        outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (io.OutReady) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fprenorm.sv
// Scoreboard bench for fprenorm: directed operands push expected results, a monitor
// compares data and latency whenever the normalizer presents a result.
module tb_fprenorm;
    import fprenorm_pkg::*;

    typedef struct {
        logic [MW-1:0]    m;
        logic [EW-1:0]    e;
        logic             z;
        logic [LOGNF-1:0] sh;
        int               lat;
        int               acc;
    } expT;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   lastAcc;
    bit   seen;
    expT  expQ[$];

    fprenorm_if io ();

    fprenorm dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: latency on first sight of OutValid, data on the handshake.
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (io.OutValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=OutValid=1 expected=OutValid=0 (cycle %0d)", cyc);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 64'(cyc - expQ[0].acc), 64'(expQ[0].lat));
                end
                if (io.OutReady) begin
                    expT x;
                    x = expQ.pop_front();
                    seen = 1'b0;
                    chk("OutM", 64'(io.OutM), 64'(x.m));
                    chk("OutE", 64'(io.OutE), 64'(x.e));
                    chk("OutZero", 64'(io.OutZero), 64'(x.z));
                    chk("OutShift", 64'(io.OutShift), 64'(x.sh));
                end
            end
        end
    end

    // Present an operand at posedge+1 and hold it until it is taken.
    task automatic send(input logic [MW-1:0] m, input logic [NE-1:0] e,
                        input logic [MW-1:0] xm, input logic [EW-1:0] xe,
                        input logic xz, input logic [LOGNF-1:0] xs, input int lat);
        bit  got;
        expT x;
        got        = 1'b0;
        io.InValid = 1'b1;
        io.InM     = m;
        io.InE     = e;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (io.InReady && !io.Flush) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            x.m = xm; x.e = xe; x.z = xz; x.sh = xs; x.lat = lat; x.acc = cyc;
            lastAcc = cyc;
            expQ.push_back(x);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=InReady=0 expected=InReady=1 (cycle %0d)", cyc);
        end
        @(posedge clk);
        #1;
        io.InValid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (expQ.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 64'(expQ.size()), 64'd0);
    endtask

    task automatic chkResetOuts(input string tag);
        chk({tag, "_OutValid"}, 64'(io.OutValid), 64'd0);
        chk({tag, "_OutM"}, 64'(io.OutM), 64'd0);
        chk({tag, "_OutE"}, 64'(io.OutE), 64'd0);
        chk({tag, "_OutZero"}, 64'(io.OutZero), 64'd0);
        chk({tag, "_OutShift"}, 64'(io.OutShift), 64'd0);
        chk({tag, "_InReady"}, 64'(io.InReady), 64'd0);
    endtask

    localparam logic [MW-1:0] LEAD = MW'(1) << NF;

    initial begin
        checks = 0; errors = 0; cyc = 0; seen = 1'b0; lastAcc = 0;
        reset = 1'b1;
        io.Flush = 1'b0; io.InValid = 1'b0; io.InM = '0; io.InE = '0; io.OutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chkResetOuts("reset");
        reset = 1'b0;
        #1;
        chk("InReady_after_reset", 64'(io.InReady), 64'd1);
        @(posedge clk);
        #1;

        // Normal, subnormals of several depths, and zeros.
        send(LEAD, NE'(11'h3FF), LEAD, EW'(1023), 1'b0, LOGNF'(0), 1);
        drain();
        send(MW'(1), '0, LEAD, EW'(-51), 1'b0, LOGNF'(52), 15);
        drain();
        send(MW'(53'h0_8000_0000_0000), '0, LEAD, EW'(-4), 1'b0, LOGNF'(5), 3);
        drain();
        send('0, '0, '0, '0, 1'b1, LOGNF'(0), 1);
        drain();
        send(MW'(1) << (NF - 1), NE'(5), LEAD, EW'(4), 1'b0, LOGNF'(1), 2);
        drain();
        send((MW'(1) << (NF - 4)) | MW'(1), '0, LEAD | MW'(16), EW'(-3), 1'b0, LOGNF'(4), 3);
        drain();
        send(LEAD | MW'(12'h123), NE'(11'h7FE), LEAD | MW'(12'h123), EW'(2046), 1'b0, LOGNF'(0), 1);
        drain();
        send('0, NE'(16), '0, '0, 1'b1, LOGNF'(0), 1);
        drain();

        // Flush mid-shift: result discarded, block ready again next cycle.
        send(MW'(1), '0, LEAD, EW'(-51), 1'b0, LOGNF'(52), 15);
        while (cyc != lastAcc + 5) begin
            @(posedge clk);
            #1;
        end
        io.Flush = 1'b1;
        expQ.delete();
        seen = 1'b0;
        @(posedge clk);
        #1;
        io.Flush = 1'b0;
        chk("flush_InReady", 64'(io.InReady), 64'd1);
        chk("flush_OutValid", 64'(io.OutValid), 64'd0);
        repeat (15) @(posedge clk);
        #1;
        send(MW'(53'h0_8000_0000_0000), '0, LEAD, EW'(-4), 1'b0, LOGNF'(5), 3);
        drain();

        // Stall in DONE for 10 cycles.
        io.OutReady = 1'b0;
        send(MW'(1) << (NF - 1), NE'(5), LEAD, EW'(4), 1'b0, LOGNF'(1), 2);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("stall_OutValid", 64'(io.OutValid), 64'd1);
            chk("stall_OutM", 64'(io.OutM), 64'(LEAD));
            chk("stall_OutE", 64'(io.OutE), 64'(EW'(4)));
            chk("stall_InReady", 64'(io.InReady), 64'd0);
            @(posedge clk);
            #1;
        end
        io.OutReady = 1'b1;
        @(posedge clk);
        #1;
        chk("release_InReady", 64'(io.InReady), 64'd1);
        chk("release_OutValid", 64'(io.OutValid), 64'd0);
        chk("release_drained", 64'(expQ.size()), 64'd0);

        // Reset asserted mid-shift.
        send(MW'(1), '0, LEAD, EW'(-51), 1'b0, LOGNF'(52), 15);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1;
        chkResetOuts("midreset");
        reset = 1'b0;
        #1;
        chk("midreset_InReady_after", 64'(io.InReady), 64'd1);
        @(posedge clk);
        #1;
        send(LEAD, NE'(11'h3FF), LEAD, EW'(1023), 1'b0, LOGNF'(0), 1);
        drain();

        repeat (3) @(posedge clk);
        chk("queue_empty_at_end", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
